// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default parameter values.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_BUSY_TMO = 15;

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: picks the first asserted request after ptr,
// wrapping, and returns it as a one-hot grant plus its index.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Walk from the farthest offset down to the nearest so the closest hit wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = N; off >= 1; off--) begin
      cand     = (int'(ptr) + off) % N;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        grant           = '0;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ requesters with round-robin
// arbitration, one frame in flight, and a timeout on the busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BUSY_TMO = DEF_BUSY_TMO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_par_en,
  input  logic [N_REQ-1:0]           req_par_type,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_data_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_parity_en,
  output logic                       tx_parity_type,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       frame_done,
  output logic                       tmo_err
);

  localparam int            IW       = $clog2(N_REQ);
  localparam int            TW       = $clog2(BUSY_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] last_grant;
  logic [TW-1:0] tmo_cnt;
  logic [N_REQ-1:0] rr_grant;
  logic [IW-1:0] rr_idx;
  logic          accept;

  rr_select #(.N(N_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (last_grant),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Handshake: a requester transfers on a cycle where req_valid & req_ready;
  // req_ready is only offered in IDLE, combinationally, to the RR winner.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    accept        = 1'b0;
    tx_data_valid = 1'b0;
    frame_done    = 1'b0;
    tmo_err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst ? rr_grant : '0;
        accept    = |req_ready;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        tx_data_valid = 1'b1;
        state_nxt     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data        <= '0;
      tx_parity_en   <= 1'b0;
      tx_parity_type <= 1'b0;
      grant_id       <= '0;
      last_grant     <= IW'(N_REQ - 1);
      tmo_cnt        <= '0;
    end else begin
      if (accept) begin
        tx_data        <= req_data[rr_idx*DATA_W +: DATA_W];
        tx_parity_en   <= req_par_en[rr_idx];
        tx_parity_type <= req_par_type[rr_idx];
        grant_id       <= rr_idx;
      end
      if (frame_done || tmo_err) last_grant <= grant_id;
      // Cleared while issuing so it starts at zero on WAIT_BUSY entry; saturates.
      if (state == ISSUE)
        tmo_cnt <= '0;
      else if (state == WAIT_BUSY && !tx_busy && tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single frame, round robin,
// busy timeout, reset mid-frame and a requester withdrawing its request.
module tb_uart_tx_arbiter;

  localparam int N_REQ    = 4;
  localparam int DATA_W   = 8;
  localparam int BUSY_TMO = 15;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_par_en;
  logic [N_REQ-1:0]        req_par_type;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_data_valid;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_parity_en;
  logic                    tx_parity_type;
  logic                    tx_busy;
  logic [1:0]              grant_id;
  logic                    frame_done;
  logic                    tmo_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BUSY_TMO(BUSY_TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_par_en     (req_par_en),
    .req_par_type   (req_par_type),
    .req_ready      (req_ready),
    .tx_data_valid  (tx_data_valid),
    .tx_data        (tx_data),
    .tx_parity_en   (tx_parity_en),
    .tx_parity_type (tx_parity_type),
    .tx_busy        (tx_busy),
    .grant_id       (grant_id),
    .frame_done     (frame_done),
    .tmo_err        (tmo_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    req_valid    = '0;
    req_data     = '0;
    req_par_en   = '0;
    req_par_type = '0;
    tx_busy      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if ({tx_data_valid, tx_data, tx_parity_en, tx_parity_type} !== 11'd0) begin
      errors++; $display("FAIL reset_tx_outputs got=%b/%h/%b/%b exp=0/00/0/0",
                          tx_data_valid, tx_data, tx_parity_en, tx_parity_type);
    end
    checks++;
    if ({grant_id, frame_done, tmo_err} !== 4'd0) begin
      errors++; $display("FAIL reset_status got=%0d/%b/%b exp=0/0/0", grant_id, frame_done, tmo_err);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    int done_cnt;
    int tmo_cnt;
    req_valid             = 4'b0100;
    req_data[2*DATA_W +: DATA_W] = 8'hA5;
    req_par_en[2]         = 1'b1;
    req_par_type[2]       = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_req_ready got=%b exp=0100", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL single_issue got=%b/%h exp=1/a5", tx_data_valid, tx_data);
    end
    checks++;
    if (tx_parity_en !== 1'b1 || tx_parity_type !== 1'b1 || grant_id !== 2'd2) begin
      errors++; $display("FAIL single_latch got=%b/%b/%0d exp=1/1/2", tx_parity_en, tx_parity_type, grant_id);
    end
    step();
    tx_busy = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_one_cycle got=%b exp=0", tx_data_valid);
    end
    done_cnt = 0;
    tmo_cnt  = 0;
    repeat (10) begin
      step();
      @(negedge clk);
      done_cnt += int'(frame_done);
      tmo_cnt  += int'(tmo_err);
    end
    step();
    tx_busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      done_cnt += int'(frame_done);
      tmo_cnt  += int'(tmo_err);
      step();
    end
    checks++;
    if (done_cnt != 1 || tmo_cnt != 0) begin
      errors++; $display("FAIL single_frame_done got=%0d/%0d exp=1/0", done_cnt, tmo_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_ready = 4'b0001 << (f % 4);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_order_%0d got=%b exp=%b", f, req_ready, exp_ready);
      end
      step();
      @(negedge clk);
      checks++;
      if (grant_id !== 2'(f % 4) || req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_grant_%0d got=%0d/%b exp=%0d/0000", f, grant_id, req_ready, f % 4);
      end
      step();
      tx_busy = 1'b1;
      repeat (3) step();
      tx_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_done_before_ready_%0d got=%b/%b exp=1/0000", f, frame_done, req_ready);
      end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int early;
    logic seen;
    int done_cnt;
    do_reset();
    req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL tmo_first_grant got=%b exp=0001", req_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b1) begin
      errors++; $display("FAIL tmo_issue got=%b exp=1", tx_data_valid);
    end
    early    = 0;
    seen     = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= BUSY_TMO; i++) begin
      @(negedge clk);
      done_cnt += int'(frame_done);
      if (i < BUSY_TMO) early += int'(tmo_err);
      else              seen = tmo_err;
    end
    checks++;
    if (early != 0 || seen !== 1'b1 || done_cnt != 0) begin
      errors++; $display("FAIL tmo_pulse got=early%0d/last%b/done%0d exp=0/1/0", early, seen, done_cnt);
    end
    @(negedge clk);
    checks++;
    if (tmo_err !== 1'b0 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL tmo_next_grant got=%b/%b exp=0/0010", tmo_err, req_ready);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid_frame();
    int done_cnt;
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DATA_W +: DATA_W] = 8'h3C;
    req_par_en[2] = 1'b1;
    step();
    req_valid = '0;
    step();
    tx_busy = 1'b1;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h3C || grant_id !== 2'd2) begin
      errors++; $display("FAIL midrst_before got=%h/%0d exp=3c/2", tx_data, grant_id);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({tx_data, tx_parity_en, grant_id, tx_data_valid} !== 12'd0) begin
      errors++; $display("FAIL midrst_outputs got=%h/%b/%0d/%b exp=00/0/0/0",
                          tx_data, tx_parity_en, grant_id, tx_data_valid);
    end
    tx_busy   = 1'b0;
    req_valid = 4'b1111;
    done_cnt  = 0;
    repeat (3) begin
      @(negedge clk);
      done_cnt += int'(frame_done) + int'(tmo_err);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL midrst_ready_in_reset got=%b exp=0000", req_ready);
      end
    end
    checks++;
    if (done_cnt != 0) begin
      errors++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_restart got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_drop_valid();
    int acks;
    int unstable;
    int done_cnt;
    do_reset();
    req_valid = 4'b0001;
    req_data[0*DATA_W +: DATA_W] = 8'h5A;
    req_data[1*DATA_W +: DATA_W] = 8'h77;
    req_par_en   = 4'b0010;
    req_par_type = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL drop_first_grant got=%b exp=0001", req_ready);
    end
    acks     = 0;
    unstable = 0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) req_valid = 4'b0010;
      if (i == 1) tx_busy   = 1'b1;
      if (i == 5) req_valid = 4'b0000;
      if (i == 6) tx_busy   = 1'b0;
      @(negedge clk);
      acks     += int'(req_ready[1]);
      done_cnt += int'(frame_done);
      if (tx_data !== 8'h5A || tx_parity_en !== 1'b0 || tx_parity_type !== 1'b1 || grant_id !== 2'd0)
        unstable++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL drop_no_ack got=%0d exp=0", acks);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL drop_stable got=%0d exp=0", unstable);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL drop_frame_done got=%0d exp=1", done_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid_frame();
    test_drop_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 8, frame payload width.
REQ-003 Parameter BUSY_TMO, default 15, cycles allowed between issue and transmitter busy rising.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester frame request.
- req_data  in  N_REQ*DATA_W  payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- req_par_en  in  N_REQ  per-requester parity enable.
- req_par_type  in  N_REQ  per-requester parity type (1 = odd, 0 = even).
- req_ready  out  N_REQ  one-hot accept strobe.
- tx_data_valid  out  1  start strobe to transmitter.
- tx_data  out  DATA_W  latched payload.
- tx_parity_en  out  1  latched parity enable.
- tx_parity_type  out  1  latched parity type.
- tx_busy  in  1  transmitter busy.
- grant_id  out  $clog2(N_REQ)  index of the current owner.
- frame_done  out  1  one-cycle pulse when a frame completes.
- tmo_err  out  1  one-cycle pulse when busy never rose.

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-006 In IDLE, req_ready SHALL be combinational: one-hot at the round-robin winner among asserted req_valid, zero if none asserted; a transfer occurs on req_valid & req_ready.
REQ-007 Round-robin search SHALL start at (last_grant+1) mod N_REQ and wrap; last_grant is N_REQ-1 after reset, so requester 0 has first priority.
REQ-008 On transfer, the winner's data, par_en and par_type SHALL be latched into tx_data/tx_parity_en/tx_parity_type, grant_id SHALL be set to the winner, and the FSM SHALL go to ISSUE.
REQ-009 ISSUE SHALL hold tx_data_valid=1 for exactly one cycle (the cycle after transfer), then go to WAIT_BUSY.
REQ-010 WAIT_BUSY SHALL move to WAIT_DONE on tx_busy=1; if tx_busy stays 0 for BUSY_TMO cycles, the block SHALL pulse tmo_err, update last_grant and go to IDLE.
REQ-011 WAIT_DONE SHALL, on tx_busy=0, pulse frame_done for one cycle, set last_grant=grant_id and go to IDLE.
REQ-012 req_ready SHALL be 0 in every state other than IDLE; at most one frame is in flight.
REQ-013 tx_data, tx_parity_en, tx_parity_type and grant_id SHALL hold stable from transfer until the next transfer.
REQ-014 A requester dropping req_valid before acceptance SHALL simply lose arbitration; no state change.
REQ-015 The timeout counter SHALL clear on entry to WAIT_BUSY and saturate; it never wraps.
REQ-016 Minimum frame-to-frame spacing SHALL be 1 IDLE cycle after frame_done.

Reset
REQ-017 While rst=0, state SHALL be IDLE and all outputs 0, including tx_data and grant_id; last_grant SHALL be N_REQ-1 and the timeout counter 0.
REQ-018 Reset asserted mid-frame SHALL abort immediately without frame_done or tmo_err; after release, arbitration restarts from requester 0.

Structure
REQ-019 The FSM state enum and the default parameter values SHALL live in a shared package uart_pkg.
REQ-020 Round-robin selection SHALL be a sub-module rr_select (inputs: request vector and pointer; output: one-hot grant and index).

Verification
REQ-021 Single requester: req_valid[2]=1, data 8'hA5, par_en=1, odd parity -> req_ready[2] pulses; next cycle tx_data_valid=1 with tx_data=8'hA5; busy pulse of 11 cycles -> one frame_done.
REQ-022 All four requesting continuously -> grant order 0,1,2,3,0 and each frame_done precedes the next req_ready.
REQ-023 tx_busy held at 0 after issue -> tmo_err pulses after 15 cycles, then the next requester is granted.
REQ-024 rst pulled low during WAIT_DONE -> outputs 0 at once, no frame_done; after release with req_valid=4'b1111, requester 0 is granted first.
REQ-025 req_valid[1] asserts then drops while requester 0's frame is in flight -> requester 1 is never acknowledged; requester 0's outputs stay stable throughout.
